// File: rtl/rf_pkg.sv
// Shared constants and types for the decode-stage register file.
package rf_pkg;

    // Default data width and register count.
    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    // Architectural zero register index.
    localparam int ZERO_REG = 0;

    // Register index type for the default register count. Instances with a
    // different NREGS size their index ports from their own AW.
    typedef logic [AW_DEFAULT-1:0] reg_idx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when an
// instruction with that destination issues and cleared when writeback lands.
// Also provides the two busy lookups used by decode for stall detection.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS  = NREGS_DEFAULT,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_issue_valid,
    input  logic [AW-1:0] i_issue_rd,
    input  logic          i_flush,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_rd,
    input  logic [AW-1:0] i_rs1,
    input  logic [AW-1:0] i_rs2,
    output logic          o_rs1_busy,
    output logic          o_rs2_busy
);

    // Pending view indexed by register number; entry 0 is a constant zero so
    // x0 can never look busy.
    logic [NREGS-1:0] w_pend_view;
    logic             w_wr_valid;
    logic             w_fwd1;
    logic             w_fwd2;

    assign w_pend_view[ZERO_REG] = 1'b0;
    assign w_wr_valid = i_wr_en && (i_wr_rd != AW'(ZERO_REG));

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_pend
            logic r_pending;
            logic w_set;
            logic w_clr;

            assign w_set = i_issue_valid && (i_issue_rd == AW'(gi));
            assign w_clr = w_wr_valid && (i_wr_rd == AW'(gi));

            // Flush squashes everything including this cycle's issue; a new
            // issue beats a same-cycle writeback since it is the newer producer.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_pending <= 1'b0;
                end else if (i_flush) begin
                    r_pending <= 1'b0;
                end else if (w_set) begin
                    r_pending <= 1'b1;
                end else if (w_clr) begin
                    r_pending <= 1'b0;
                end
            end

            assign w_pend_view[gi] = r_pending;
        end
    endgenerate

    // A writeback to the queried register forwards its value, so with bypass
    // enabled the operand is no longer a hazard this cycle.
    assign w_fwd1 = BYPASS && w_wr_valid && (i_wr_rd == i_rs1);
    assign w_fwd2 = BYPASS && w_wr_valid && (i_wr_rd == i_rs2);

    assign o_rs1_busy = w_pend_view[i_rs1] && !w_fwd1;
    assign o_rs2_busy = w_pend_view[i_rs2] && !w_fwd2;

endmodule

// File: rtl/reg_file_sb.sv
// Decode-stage register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero, optional write-to-read bypass and a
// pending-write scoreboard for hazard stalls.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWrite,
    input  logic [AW-1:0]   Rd,
    input  logic [XLEN-1:0] Write_data,
    input  logic [AW-1:0]   Rs1,
    input  logic [AW-1:0]   Rs2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            flush,
    output logic            rs1_busy,
    output logic            rs2_busy
);

    // Register contents indexed by register number; entry 0 is constant zero
    // and has no storage behind it.
    logic [XLEN-1:0] w_view [NREGS];
    logic            w_wr_valid;
    logic            w_hit1;
    logic            w_hit2;

    assign w_view[ZERO_REG] = '0;
    assign w_wr_valid = RegWrite && (Rd != AW'(ZERO_REG));

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            logic [XLEN-1:0] r_data;

            // Writeback into this register; reset takes priority over any write.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_data <= '0;
                end else if (RegWrite && (Rd == AW'(gi))) begin
                    r_data <= Write_data;
                end
            end

            assign w_view[gi] = r_data;
        end
    endgenerate

    // Same-cycle forwarding of writeback data to the read ports.
    assign w_hit1 = BYPASS && w_wr_valid && (Rd == Rs1);
    assign w_hit2 = BYPASS && w_wr_valid && (Rd == Rs2);

    assign read_data1 = w_hit1 ? Write_data : w_view[Rs1];
    assign read_data2 = w_hit2 ? Write_data : w_view[Rs2];

    rf_scoreboard #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .i_flush       (flush),
        .i_wr_en       (RegWrite),
        .i_wr_rd       (Rd),
        .i_rs1         (Rs1),
        .i_rs2         (Rs2),
        .o_rs1_busy    (rs1_busy),
        .o_rs2_busy    (rs2_busy)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypassing and a non-bypassing 32x32 instance share
// stimulus; a 64-bit, 16-entry instance covers the wide/small configuration.
module tb_reg_file_sb;

    localparam int S_B_RD1 = 0, S_B_RD2 = 1, S_B_BZ1 = 2, S_B_BZ2 = 3;
    localparam int S_N_RD1 = 4, S_N_RD2 = 5, S_N_BZ1 = 6, S_N_BZ2 = 7;
    localparam int S_W_RD1 = 8, S_W_RD2 = 9, S_W_BZ1 = 10, S_W_BZ2 = 11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        we = 1'b0, iv = 1'b0, fl = 1'b0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0, ird = '0;
    logic [31:0] wd = '0;
    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_bz1, b_bz2, n_bz1, n_bz2;

    logic        w_we = 1'b0, w_iv = 1'b0, w_fl = 1'b0;
    logic [3:0]  w_rd = '0, w_rs1 = '0, w_rs2 = '0, w_ird = '0;
    logic [63:0] w_wd = '0;
    logic [63:0] w_rd1, w_rd2;
    logic        w_bz1, w_bz2;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset), .RegWrite(we), .Rd(rd), .Write_data(wd),
        .Rs1(rs1), .Rs2(rs2), .read_data1(b_rd1), .read_data2(b_rd2),
        .issue_valid(iv), .issue_rd(ird), .flush(fl),
        .rs1_busy(b_bz1), .rs2_busy(b_bz2)
    );

    reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset), .RegWrite(we), .Rd(rd), .Write_data(wd),
        .Rs1(rs1), .Rs2(rs2), .read_data1(n_rd1), .read_data2(n_rd2),
        .issue_valid(iv), .issue_rd(ird), .flush(fl),
        .rs1_busy(n_bz1), .rs2_busy(n_bz2)
    );

    reg_file_sb #(.XLEN(64), .NREGS(16), .BYPASS(1'b1)) dut_w (
        .clk(clk), .reset(reset), .RegWrite(w_we), .Rd(w_rd), .Write_data(w_wd),
        .Rs1(w_rs1), .Rs2(w_rs2), .read_data1(w_rd1), .read_data2(w_rd2),
        .issue_valid(w_iv), .issue_rd(w_ird), .flush(w_fl),
        .rs1_busy(w_bz1), .rs2_busy(w_bz2)
    );

    function automatic logic [63:0] observe(int sel);
        case (sel)
            S_B_RD1: return {32'h0, b_rd1};
            S_B_RD2: return {32'h0, b_rd2};
            S_B_BZ1: return {63'h0, b_bz1};
            S_B_BZ2: return {63'h0, b_bz2};
            S_N_RD1: return {32'h0, n_rd1};
            S_N_RD2: return {32'h0, n_rd2};
            S_N_BZ1: return {63'h0, n_bz1};
            S_N_BZ2: return {63'h0, n_bz2};
            S_W_RD1: return w_rd1;
            S_W_RD2: return w_rd2;
            S_W_BZ1: return {63'h0, w_bz1};
            default: return {63'h0, w_bz2};
        endcase
    endfunction

    task automatic push(input string n, input int sel, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.sel  = sel;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic drv32(input logic a_we, input logic [4:0] a_rd, input logic [31:0] a_wd,
                         input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                         input logic a_iv, input logic [4:0] a_ird, input logic a_fl);
        we = a_we; rd = a_rd; wd = a_wd; rs1 = a_rs1; rs2 = a_rs2;
        iv = a_iv; ird = a_ird; fl = a_fl;
    endtask

    task automatic drvw(input logic a_we, input logic [3:0] a_rd, input logic [63:0] a_wd,
                        input logic [3:0] a_rs1, input logic [3:0] a_rs2,
                        input logic a_iv, input logic [3:0] a_ird, input logic a_fl);
        w_we = a_we; w_rd = a_rd; w_wd = a_wd; w_rs1 = a_rs1; w_rs2 = a_rs2;
        w_iv = a_iv; w_ird = a_ird; w_fl = a_fl;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 2; s++) begin
            @(posedge clk); #1;
            case (s)
                0: begin
                    reset = 1'b0;
                    drv32(0, 0, 0, 0, 0, 0, 0, 0);
                    drvw(0, 0, 0, 0, 0, 0, 0, 0);
                end
                default: begin
                    reset = 1'b1;
                    drv32(0, 0, 0, 5, 31, 0, 0, 0);
                    drvw(0, 0, 0, 3, 15, 0, 0, 0);
                    for (int k = 0; k < 12; k++) push($sformatf("reset_out%0d", k), k, 64'h0);
                end
            endcase
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe(e.sel);
                tests_run++;
                if (got !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                end else $display("[TB] %s ok %h", e.name, got);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 2; s++) begin
            @(posedge clk); #1;
            case (s)
                0: begin
                    drv32(1, 5, 32'hDEADBEEF, 1, 0, 0, 0, 0);
                    push("wr_x0_port2", S_B_RD2, 64'h0);
                end
                default: begin
                    drv32(0, 0, 0, 5, 0, 0, 0, 0);
                    push("wr_b_x5", S_B_RD1, 64'hDEADBEEF);
                    push("wr_b_rs2_x0", S_B_RD2, 64'h0);
                    push("wr_n_x5", S_N_RD1, 64'hDEADBEEF);
                    push("wr_n_rs2_x0", S_N_RD2, 64'h0);
                end
            endcase
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe(e.sel);
                tests_run++;
                if (got !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                end else $display("[TB] %s ok %h", e.name, got);
            end
        end
    endtask

    task automatic test_x0();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 2; s++) begin
            @(posedge clk); #1;
            case (s)
                0: begin
                    drv32(1, 0, 32'hFFFFFFFF, 0, 5, 1, 0, 0);
                    push("x0_b_no_bypass", S_B_RD1, 64'h0);
                    push("x0_n_no_bypass", S_N_RD1, 64'h0);
                    push("x0_b_x5_same", S_B_RD2, 64'hDEADBEEF);
                end
                default: begin
                    drv32(0, 0, 0, 0, 5, 0, 0, 0);
                    push("x0_b_read", S_B_RD1, 64'h0);
                    push("x0_b_busy", S_B_BZ1, 64'h0);
                    push("x0_n_busy", S_N_BZ1, 64'h0);
                    push("x0_b_x5_kept", S_B_RD2, 64'hDEADBEEF);
                    push("x0_n_x5_kept", S_N_RD2, 64'hDEADBEEF);
                end
            endcase
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe(e.sel);
                tests_run++;
                if (got !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                end else $display("[TB] %s ok %h", e.name, got);
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 2; s++) begin
            @(posedge clk); #1;
            case (s)
                0: begin
                    drv32(1, 10, 32'hAAAA5555, 10, 10, 0, 0, 0);
                    push("byp_b_rd1", S_B_RD1, 64'hAAAA5555);
                    push("byp_b_rd2", S_B_RD2, 64'hAAAA5555);
                    push("byp_n_rd1_old", S_N_RD1, 64'h0);
                    push("byp_n_rd2_old", S_N_RD2, 64'h0);
                end
                default: begin
                    drv32(0, 0, 0, 10, 10, 0, 0, 0);
                    push("byp_b_rd1_next", S_B_RD1, 64'hAAAA5555);
                    push("byp_b_rd2_next", S_B_RD2, 64'hAAAA5555);
                    push("byp_n_rd1_next", S_N_RD1, 64'hAAAA5555);
                    push("byp_n_rd2_next", S_N_RD2, 64'hAAAA5555);
                end
            endcase
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe(e.sel);
                tests_run++;
                if (got !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                end else $display("[TB] %s ok %h", e.name, got);
            end
        end
    endtask

    task automatic test_busy();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 9; s++) begin
            @(posedge clk); #1;
            case (s)
                0: begin
                    drv32(0, 0, 0, 15, 15, 1, 15, 0);
                    push("busy_b_issue_cycle", S_B_BZ1, 64'h0);
                    push("busy_n_issue_cycle", S_N_BZ1, 64'h0);
                end
                1: begin
                    drv32(0, 0, 0, 15, 15, 0, 0, 0);
                    push("busy_b_set1", S_B_BZ1, 64'h1);
                    push("busy_b_set2", S_B_BZ2, 64'h1);
                    push("busy_n_set1", S_N_BZ1, 64'h1);
                end
                2: begin
                    drv32(1, 15, 32'h12345678, 15, 0, 0, 0, 0);
                    push("busy_b_wb_fwd", S_B_BZ1, 64'h0);
                    push("busy_b_wb_data", S_B_RD1, 64'h12345678);
                    push("busy_n_wb_still", S_N_BZ1, 64'h1);
                    push("busy_n_wb_old", S_N_RD1, 64'h0);
                end
                3: begin
                    drv32(0, 0, 0, 15, 15, 0, 0, 0);
                    push("busy_b_cleared", S_B_BZ1, 64'h0);
                    push("busy_n_cleared", S_N_BZ1, 64'h0);
                    push("busy_n_data", S_N_RD1, 64'h12345678);
                end
                4: begin
                    drv32(0, 0, 0, 15, 0, 1, 15, 0);
                    push("busy_b_reissue", S_B_BZ1, 64'h0);
                end
                5: begin
                    drv32(1, 15, 32'h11, 15, 0, 1, 15, 0);
                    push("busy_b_setclr_fwd", S_B_BZ1, 64'h0);
                    push("busy_b_setclr_data", S_B_RD1, 64'h11);
                    push("busy_n_setclr", S_N_BZ1, 64'h1);
                end
                6: begin
                    drv32(0, 0, 0, 15, 0, 0, 0, 0);
                    push("busy_b_set_wins", S_B_BZ1, 64'h1);
                    push("busy_n_set_wins", S_N_BZ1, 64'h1);
                    push("busy_b_setclr_store", S_B_RD1, 64'h11);
                end
                7: begin
                    drv32(1, 15, 32'h22, 15, 0, 0, 0, 0);
                    push("busy_n_final_wb", S_N_BZ1, 64'h1);
                end
                default: begin
                    drv32(0, 0, 0, 15, 0, 0, 0, 0);
                    push("busy_b_final", S_B_BZ1, 64'h0);
                    push("busy_n_final", S_N_BZ1, 64'h0);
                end
            endcase
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe(e.sel);
                tests_run++;
                if (got !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                end else $display("[TB] %s ok %h", e.name, got);
            end
        end
    endtask

    task automatic test_flush();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            case (s)
                0: drv32(0, 0, 0, 0, 0, 1, 3, 0);
                1: begin
                    drv32(0, 0, 0, 3, 7, 1, 7, 0);
                    push("fl_b_x3_busy", S_B_BZ1, 64'h1);
                    push("fl_b_x7_notyet", S_B_BZ2, 64'h0);
                end
                2: begin
                    drv32(1, 3, 32'h333, 3, 7, 1, 9, 1);
                    push("fl_b_x3_fwd", S_B_BZ1, 64'h0);
                    push("fl_b_x7_busy", S_B_BZ2, 64'h1);
                    push("fl_n_x3_busy", S_N_BZ1, 64'h1);
                    push("fl_n_x7_busy", S_N_BZ2, 64'h1);
                end
                3: begin
                    drv32(0, 0, 0, 3, 7, 0, 0, 0);
                    push("fl_b_x3_clear", S_B_BZ1, 64'h0);
                    push("fl_b_x7_clear", S_B_BZ2, 64'h0);
                    push("fl_n_x3_clear", S_N_BZ1, 64'h0);
                    push("fl_n_x7_clear", S_N_BZ2, 64'h0);
                    push("fl_b_data_kept", S_B_RD1, 64'h333);
                    push("fl_n_data_kept", S_N_RD1, 64'h333);
                end
                default: begin
                    drv32(0, 0, 0, 9, 0, 0, 0, 0);
                    push("fl_b_x9_ignored", S_B_BZ1, 64'h0);
                    push("fl_n_x9_ignored", S_N_BZ1, 64'h0);
                end
            endcase
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe(e.sel);
                tests_run++;
                if (got !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                end else $display("[TB] %s ok %h", e.name, got);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [63:0] got;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            case (s)
                0: begin
                    drvw(1, 4, 64'h0123456789ABCDEF, 0, 0, 1, 6, 0);
                    drv32(1, 20, 32'hCAFE, 0, 0, 1, 21, 0);
                end
                1: begin
                    drvw(0, 0, 0, 4, 6, 0, 0, 0);
                    drv32(0, 0, 0, 20, 21, 0, 0, 0);
                    push("rm_w_x4_written", S_W_RD1, 64'h0123456789ABCDEF);
                    push("rm_w_x6_busy", S_W_BZ2, 64'h1);
                    push("rm_b_x20_written", S_B_RD1, 64'hCAFE);
                    push("rm_b_x21_busy", S_B_BZ2, 64'h1);
                end
                2: begin
                    reset = 1'b0;
                    drvw(1, 4, 64'hFFFFFFFFFFFFFFFF, 4, 6, 1, 8, 0);
                    drv32(1, 20, 32'hBEEF, 20, 21, 1, 22, 0);
                end
                3: begin
                    reset = 1'b1;
                    drvw(0, 0, 0, 4, 6, 0, 0, 0);
                    drv32(0, 0, 0, 20, 21, 0, 0, 0);
                    push("rm_w_x4_zero", S_W_RD1, 64'h0);
                    push("rm_w_x6_zero", S_W_RD2, 64'h0);
                    push("rm_w_x4_idle", S_W_BZ1, 64'h0);
                    push("rm_w_x6_idle", S_W_BZ2, 64'h0);
                    push("rm_b_x20_zero", S_B_RD1, 64'h0);
                    push("rm_b_x21_idle", S_B_BZ2, 64'h0);
                    push("rm_n_x20_zero", S_N_RD1, 64'h0);
                end
                default: begin
                    drvw(0, 0, 0, 8, 15, 0, 0, 0);
                    drv32(0, 0, 0, 22, 5, 0, 0, 0);
                    push("rm_w_x8_not_set", S_W_BZ1, 64'h0);
                    push("rm_w_x15_zero", S_W_RD2, 64'h0);
                    push("rm_b_x22_not_set", S_B_BZ1, 64'h0);
                    push("rm_b_x5_cleared", S_B_RD2, 64'h0);
                end
            endcase
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe(e.sel);
                tests_run++;
                if (got !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                end else $display("[TB] %s ok %h", e.name, got);
            end
        end
    endtask

    // Random traffic against a reference model of registers and pending bits.
    task automatic test_back_to_back();
        exp_t e;
        logic [63:0] got;
        logic [31:0] m [32];
        bit          p [32];
        logic [31:0] eb1, eb2;
        for (int k = 0; k < 32; k++) begin
            m[k] = '0;
            p[k] = 1'b0;
        end
        for (int s = 0; s < 49; s++) begin
            @(posedge clk); #1;
            if (s == 0) begin
                reset = 1'b0;
                drv32(0, 0, 0, 0, 0, 0, 0, 0);
            end else begin
                reset = 1'b1;
                drv32(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                      ($urandom_range(0, 9) == 0));
                eb1 = (we && rd != 0 && rd == rs1) ? wd : m[rs1];
                eb2 = (we && rd != 0 && rd == rs2) ? wd : m[rs2];
                push("b2b_b_rd1", S_B_RD1, {32'h0, eb1});
                push("b2b_b_rd2", S_B_RD2, {32'h0, eb2});
                push("b2b_n_rd1", S_N_RD1, {32'h0, m[rs1]});
                push("b2b_n_rd2", S_N_RD2, {32'h0, m[rs2]});
                push("b2b_b_bz1", S_B_BZ1, {63'h0, p[rs1] && !(we && rd == rs1)});
                push("b2b_b_bz2", S_B_BZ2, {63'h0, p[rs2] && !(we && rd == rs2)});
                push("b2b_n_bz1", S_N_BZ1, {63'h0, p[rs1]});
                push("b2b_n_bz2", S_N_BZ2, {63'h0, p[rs2]});
            end
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                got = observe(e.sel);
                tests_run++;
                if (got !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %s: got %h expected %h (step %0d)", e.name, got, e.exp, s);
                end else $display("[TB] %s ok %h", e.name, got);
            end
            if (s != 0) begin
                if (we && rd != 0) m[rd] = wd;
                if (fl) begin
                    for (int k = 0; k < 32; k++) p[k] = 1'b0;
                end else begin
                    if (we && rd != 0) p[rd] = 1'b0;
                    if (iv && ird != 0) p[ird] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_busy();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
